// File: rtl/cmd_dispatcher_if.sv
// Signals between the command dispatcher, the show-ahead packet FIFO and the
// command engines. The master side is the dispatcher; the slave side is its environment.
interface cmd_dispatcher_if #(
    parameter int SIZE = 256,
    parameter int N_CH = 8
);
    logic                fifo_empty;
    logic [8*SIZE-1:0]   fifo_data;
    logic                rd_en;
    logic [N_CH-1:0]     busy;
    logic                vsync;
    logic [N_CH-1:0]     cmd_pulse;
    logic [8*SIZE-1:0]   pkt_out;
    logic                swap_lock;
    logic [N_CH-1:0]     busy_vec;
    logic [7:0]          err_opcode;
    logic                err_timeout;

    modport master (
        input  fifo_empty, fifo_data, busy, vsync,
        output rd_en, cmd_pulse, pkt_out, swap_lock, busy_vec, err_opcode, err_timeout
    );

    modport slave (
        output fifo_empty, fifo_data, busy, vsync,
        input  rd_en, cmd_pulse, pkt_out, swap_lock, busy_vec, err_opcode, err_timeout
    );
endinterface

// File: rtl/cmd_dispatcher.sv
// Pops packets from the FIFO head, routes them by opcode to one of N_CH command engines
// as one-cycle strobes, and owns the vsync-released buffer-swap lock.
module cmd_dispatcher #(
    parameter int              SIZE         = 256,
    parameter int              N_CH         = 8,
    parameter int              OPCODE_BYTE  = 2,
    parameter int              SWAP_CH      = 0,
    parameter logic [N_CH-1:0] LOCK_MASK    = N_CH'(8'h03),
    parameter int              LOCK_TIMEOUT = 2000000
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    cmd_dispatcher_if.master bus
);
    localparam int CW = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int TW = (LOCK_TIMEOUT > 0) ? $clog2(LOCK_TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_GAP, S_DROP} state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     ch_q, ch_d;
    logic              rd_en_q, rd_en_d;
    logic [N_CH-1:0]   pulse_q, pulse_d;
    logic [8*SIZE-1:0] pkt_q, pkt_d;
    logic              lock_q, lock_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic [7:0]        errop_q, errop_d;
    logic              errto_q, errto_d;
    logic              vs_q;

    logic [7:0]        head_op;
    logic [CW-1:0]     ch_head;
    logic              legal, hold, set_lock, vs_fall;

    assign head_op = bus.fifo_data[8*OPCODE_BYTE +: 8];
    assign legal   = (head_op != 8'd0) && (int'(head_op) <= N_CH);
    assign ch_head = CW'(head_op - 8'd1);
    assign hold    = legal && (bus.busy[ch_head] || (LOCK_MASK[ch_head] && lock_q));
    assign vs_fall = vs_q & ~bus.vsync;

    always_comb begin
        state_d  = state_q;
        ch_d     = ch_q;
        rd_en_d  = 1'b0;
        pulse_d  = '0;
        pkt_d    = pkt_q;
        lock_d   = lock_q;
        timer_d  = timer_q;
        errop_d  = errop_q;
        errto_d  = errto_q;
        set_lock = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (!bus.fifo_empty) begin
                    if (!legal) begin
                        rd_en_d = 1'b1;
                        if (errop_q != 8'hFF) errop_d = errop_q + 8'd1;
                        state_d = S_DROP;
                    end else if (!hold) begin
                        rd_en_d = 1'b1;
                        pkt_d   = bus.fifo_data;
                        ch_d    = ch_head;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                pulse_d  = N_CH'(1) << ch_q;
                set_lock = (ch_q == CW'(SWAP_CH));
                state_d  = S_GAP;
            end
            default: state_d = S_IDLE;
        endcase

        // A new swap beats a coincident vsync release and restarts the timeout.
        if (set_lock) begin
            lock_d  = 1'b1;
            timer_d = '0;
        end else if (lock_q) begin
            if (vs_fall) begin
                lock_d  = 1'b0;
                timer_d = '0;
            end else if (LOCK_TIMEOUT != 0 && timer_q == TW'(LOCK_TIMEOUT - 1)) begin
                lock_d  = 1'b0;
                timer_d = '0;
                errto_d = 1'b1;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= S_IDLE;
            ch_q    <= '0;
            rd_en_q <= 1'b0;
            pulse_q <= '0;
            pkt_q   <= '0;
            lock_q  <= 1'b0;
            timer_q <= '0;
            errop_q <= '0;
            errto_q <= 1'b0;
            vs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ch_q    <= ch_d;
            rd_en_q <= rd_en_d;
            pulse_q <= pulse_d;
            pkt_q   <= pkt_d;
            lock_q  <= lock_d;
            timer_q <= timer_d;
            errop_q <= errop_d;
            errto_q <= errto_d;
            vs_q    <= bus.vsync;
        end
    end

    assign bus.rd_en       = rd_en_q;
    assign bus.cmd_pulse   = pulse_q;
    assign bus.pkt_out     = pkt_q;
    assign bus.swap_lock   = lock_q;
    assign bus.busy_vec    = bus.busy | (N_CH'(lock_q) << SWAP_CH);
    assign bus.err_opcode  = errop_q;
    assign bus.err_timeout = errto_q;
endmodule

// File: tb/tb_cmd_dispatcher.sv
// Bench for cmd_dispatcher: queue-based FIFO, directed scenarios and a randomized run,
// all checked every cycle against a transaction-level model of accept/issue/lock rules.
module tb_cmd_dispatcher;
    localparam int SIZE    = 8;
    localparam int N_CH    = 8;
    localparam int OPB     = 2;
    localparam int SWAP_CH = 0;
    localparam int TMO     = 16;
    localparam int W       = 8 * SIZE;
    localparam logic [N_CH-1:0] MASK = 8'h03;

    logic clk_i  = 1'b0;
    logic rst_ni = 1'b1;
    always #5 clk_i = ~clk_i;

    cmd_dispatcher_if #(.SIZE(SIZE), .N_CH(N_CH)) bus ();

    cmd_dispatcher #(
        .SIZE(SIZE), .N_CH(N_CH), .OPCODE_BYTE(OPB), .SWAP_CH(SWAP_CH),
        .LOCK_MASK(MASK), .LOCK_TIMEOUT(TMO)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni), .bus(bus)
    );

    int total = 0;
    int bad   = 0;

    logic [W-1:0]    fq[$];
    int              cyc, last_rd, illegal, lock_cnt;
    bit              last_legal, lock_m, errto_m, vs1, vs2;
    logic [N_CH-1:0] exp_pulse_nxt;
    logic [W-1:0]    exp_pkt;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic refresh();
        bus.fifo_empty = (fq.size() == 0);
        bus.fifo_data  = (fq.size() != 0) ? fq[0] : '0;
    endtask

    task automatic push(input logic [7:0] op);
        logic [W-1:0] p;
        p = W'({$urandom, $urandom});
        p[8*OPB +: 8] = op;
        fq.push_back(p);
        refresh();
    endtask

    task automatic mreset();
        cyc = 0; last_rd = -100; last_legal = 0; illegal = 0; lock_cnt = 0;
        lock_m = 0; errto_m = 0; vs1 = 0; vs2 = 0;
        exp_pulse_nxt = '0; exp_pkt = '0;
    endtask

    // Advance one cycle, emulate the FIFO pop, then check every output against the model.
    task automatic tick();
        logic            rd_s, empty_p, lock_p, exp_rd, legal, idle_p, fall;
        logic [N_CH-1:0] busy_p, exp_pulse;
        logic [W-1:0]    head_p, popped;
        logic [7:0]      op;
        int              c;
        rd_s = bus.rd_en; busy_p = bus.busy; empty_p = bus.fifo_empty;
        head_p = bus.fifo_data; lock_p = lock_m; vs2 = vs1; vs1 = bus.vsync;
        @(posedge clk_i); #1; cyc++;
        if (rd_s && fq.size() != 0) popped = fq.pop_front();
        refresh();

        op     = head_p[8*OPB +: 8];
        legal  = (op >= 8'd1) && (int'(op) <= N_CH);
        c      = int'(op) - 1;
        idle_p = (cyc - 1 - last_rd) >= (last_legal ? 2 : 1);
        exp_rd = idle_p && !empty_p && !(legal && (busy_p[c] || (MASK[c] && lock_p)));

        exp_pulse = exp_pulse_nxt;
        exp_pulse_nxt = '0;
        if (exp_rd) begin
            last_rd = cyc; last_legal = legal;
            if (legal) begin
                exp_pkt = head_p;
                exp_pulse_nxt = N_CH'(1) << c;
            end else begin
                illegal++;
            end
        end

        fall = vs2 && !vs1;
        if (exp_pulse[SWAP_CH]) begin
            lock_m = 1; lock_cnt = 1;
        end else if (lock_m) begin
            if (fall) lock_m = 0;
            else if (lock_cnt == TMO) begin lock_m = 0; errto_m = 1; end
            else lock_cnt++;
        end

        chk("rd_en",     W'(bus.rd_en),       W'(exp_rd));
        chk("cmd_pulse", W'(bus.cmd_pulse),   W'(exp_pulse));
        chk("pkt_out",   bus.pkt_out,         exp_pkt);
        chk("swap_lock", W'(bus.swap_lock),   W'(lock_m));
        chk("busy_vec",  W'(bus.busy_vec),    W'(bus.busy | (N_CH'(lock_m) << SWAP_CH)));
        chk("err_op",    W'(bus.err_opcode),  W'(illegal > 255 ? 255 : illegal));
        chk("err_to",    W'(bus.err_timeout), W'(errto_m));
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        #1;
        chk("rst_rd",    W'(bus.rd_en),       '0);
        chk("rst_pulse", W'(bus.cmd_pulse),   '0);
        chk("rst_pkt",   bus.pkt_out,         '0);
        chk("rst_lock",  W'(bus.swap_lock),   '0);
        chk("rst_errop", W'(bus.err_opcode),  '0);
        chk("rst_errto", W'(bus.err_timeout), '0);
        fq.delete(); refresh(); mreset();
        bus.vsync = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_ni = 1'b1;
    endtask

    task automatic wait_rd(input string tag);
        int n = 0;
        do begin tick(); n++; end while (!bus.rd_en && n < 200);
        chk(tag, W'(bus.rd_en), W'(1));
    endtask

    initial begin
        int n;
        bus.fifo_empty = 1'b1; bus.fifo_data = '0; bus.busy = '0; bus.vsync = 1'b0;
        #2 do_reset();
        repeat (3) tick();

        // opcode 2, nothing busy
        push(8'h02);
        wait_rd("t1_acc");
        tick();
        chk("t1_pulse", W'(bus.cmd_pulse), W'(8'h02));
        chk("t1_pkt",   bus.pkt_out, exp_pkt);

        // opcode 5 held by busy engine
        bus.busy = 8'h10;
        push(8'h05);
        repeat (20) begin tick(); chk("t2_hold", W'(bus.rd_en), '0); end
        bus.busy = '0;
        wait_rd("t2_acc");
        tick();
        chk("t2_pulse", W'(bus.cmd_pulse), W'(8'h10));

        // swap then clear: clear waits for vsync fall
        bus.vsync = 1'b1;
        repeat (2) tick();
        push(8'h01); push(8'h02);
        wait_rd("t3_acc1");
        tick();
        chk("t3_swap", W'(bus.cmd_pulse), W'(8'h01));
        chk("t3_lock", W'(bus.swap_lock), W'(1));
        repeat (10) begin tick(); chk("t3_hold", W'(bus.rd_en), '0); end
        bus.vsync = 1'b0;
        wait_rd("t3_acc2");
        tick();
        chk("t3_clear", W'(bus.cmd_pulse), W'(8'h02));

        // illegal opcodes: popped, no pulse, counter saturates
        for (int i = 0; i < 300; i++) push((i % 2) ? 8'hFF : 8'h00);
        n = 0;
        while (fq.size() != 0 && n < 1000) begin tick(); n++; end
        repeat (2) tick();
        chk("t4_sat", W'(bus.err_opcode), W'(255));

        // swap lock released by timeout
        push(8'h01);
        wait_rd("t5_acc");
        tick();
        n = 0;
        while (bus.swap_lock && n < 40) begin n++; tick(); end
        chk("t5_len",   W'(n), W'(TMO));
        chk("t5_errto", W'(bus.err_timeout), W'(1));

        // swap issue coincident with vsync falling edge
        bus.vsync = 1'b1;
        repeat (3) tick();
        push(8'h01);
        wait_rd("t6_acc");
        bus.vsync = 1'b0;
        tick();
        chk("t6_lock", W'(bus.swap_lock), W'(1));
        tick();
        chk("t6_lock2", W'(bus.swap_lock), W'(1));

        // reset while a command is in ISSUE
        repeat (20) tick();
        push(8'h03);
        wait_rd("t6_acc2");
        do_reset();
        repeat (2) tick();

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < N_CH; b++) bus.busy[b] = ($urandom_range(3) == 0);
            bus.vsync = ((i / 37) % 2) == 1;
            if (fq.size() < 8 && $urandom_range(2) == 0) begin
                if ($urandom_range(4) == 0) push(($urandom_range(1) == 0) ? 8'h00 : 8'(9 + $urandom_range(246)));
                else push(8'(1 + $urandom_range(N_CH - 1)));
            end
            tick();
        end
        bus.busy = '0;
        n = 0;
        while (fq.size() != 0 && n < 2000) begin tick(); n++; end
        chk("drain", W'(fq.size()), '0);
        repeat (4) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end
endmodule
